hazard_ctrl: RTL

- Pipeline sequencing controller for the 5-stage MIPS core. It sits beside the forwarding unit and drives the stall, hold and flush enables of the PC, IF/ID, ID/EX and EX/MEM registers.
- Covers the three cases forwarding cannot resolve:
  - load-use interlock (1-cycle bubble);
  - taken-branch squash of IF/ID;
  - a multi-cycle mult/div operation that freezes the front of the pipe for MD_LAT cycles.
- Keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/hazard_lu_detect.sv | 19 +
 rtl/hazard_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-control types: hazard controller state encoding and register-zero constant.
package pipe_pkg;

  typedef enum logic [1:0] {
    HC_RUN     = 2'd0,
    HC_MD_BUSY = 2'd1,
    HC_MD_DONE = 2'd2
  } hc_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Down-counter width; covers the full legal MD_LAT range of 1..15.
  localparam int MD_CNT_W = 4;

endpackage

// File: rtl/hazard_lu_detect.sv
// Load-use compare between the load in EX and the source registers of the instruction in ID.
// Purely combinational, zero latency; no flow control.
module hazard_lu_detect
  import pipe_pkg::*;
(
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic [4:0] i_ex_rt,
  input  logic       i_ex_mem_read,
  output logic       o_lu
);

  logic w_src_match;

  assign w_src_match = (i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt);
  // $zero is hardwired, so a load targeting it never creates a dependency.
  assign o_lu        = i_ex_mem_read && (i_ex_rt != REG_ZERO) && w_src_match;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for load-use, taken branch and multi-cycle mult/div; enables are
// combinational from state and inputs, state and the stall-cycle counter update on the clock edge.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IDRs,
  input  logic [4:0]       IDRt,
  input  logic [4:0]       IDEXRt,
  input  logic             IDEXMemRead,
  input  logic             branchTaken,
  input  logic             exMdOp,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             ifidFlush,
  output logic             idexWrite,
  output logic             idexFlush,
  output logic             exmemFlush,
  output logic             mdBusy,
  output logic             mdDone,
  output logic [CNT_W-1:0] stallCycles
);

  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LAT - 1);

  hc_state_t            r_state;
  hc_state_t            w_state_nxt;
  logic [MD_CNT_W-1:0]  r_md_cnt;
  logic [MD_CNT_W-1:0]  w_md_cnt_nxt;
  logic [CNT_W-1:0]     r_stall_cnt;
  logic                 w_lu;

  hazard_lu_detect u_lu_detect (
    .i_id_rs       (IDRs),
    .i_id_rt       (IDRt),
    .i_ex_rt       (IDEXRt),
    .i_ex_mem_read (IDEXMemRead),
    .o_lu          (w_lu)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    pcWrite      = 1'b1;
    ifidWrite    = 1'b1;
    ifidFlush    = 1'b0;
    idexWrite    = 1'b1;
    idexFlush    = 1'b0;
    exmemFlush   = 1'b0;
    mdBusy       = 1'b0;
    mdDone       = 1'b0;

    case (r_state)
      HC_RUN: begin
        if (exMdOp) begin
          w_state_nxt  = HC_MD_BUSY;
          w_md_cnt_nxt = MD_LOAD;
          pcWrite      = 1'b0;
          ifidWrite    = 1'b0;
          idexWrite    = 1'b0;
          exmemFlush   = 1'b1;
        end else if (w_lu) begin
          pcWrite      = 1'b0;
          ifidWrite    = 1'b0;
          idexFlush    = 1'b1;
        end else if (branchTaken) begin
          ifidFlush    = 1'b1;
        end
      end

      HC_MD_BUSY: begin
        pcWrite    = 1'b0;
        ifidWrite  = 1'b0;
        idexWrite  = 1'b0;
        exmemFlush = 1'b1;
        mdBusy     = 1'b1;
        // Leave once the decremented count reaches zero; a zero load still costs one busy cycle.
        if (r_md_cnt <= MD_CNT_W'(1)) begin
          w_state_nxt  = HC_MD_DONE;
          w_md_cnt_nxt = '0;
        end else begin
          w_md_cnt_nxt = r_md_cnt - 1'b1;
        end
      end

      HC_MD_DONE: begin
        mdDone      = 1'b1;
        w_state_nxt = HC_RUN;
        // exMdOp still reflects the departing mult/div, so only lu and branch are honoured.
        if (w_lu) begin
          pcWrite   = 1'b0;
          ifidWrite = 1'b0;
          idexFlush = 1'b1;
        end else if (branchTaken) begin
          ifidFlush = 1'b1;
        end
      end

      default: begin
        w_state_nxt  = HC_RUN;
        w_md_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= HC_RUN;
      r_md_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
      if (!pcWrite && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign stallCycles = r_stall_cnt;

endmodule
